// File: rtl/fifo_rd_stream.sv
// Reads words from a registered-output FIFO and streams them out as OUT_WIDTH slices.
// One read per word; LOAD captures the word the cycle after the read, SEND serialises it.
`timescale 1ns/1ps
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int MSB_FIRST  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_last
);

   localparam int NSLICE = DATA_WIDTH / OUT_WIDTH;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  sreg_q, sreg_d, sreg_next;
   logic                   valid_q, valid_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic                   last_q, last_d;
   logic                   hs, last_hs;

   // The slice on the wire is always the head of the shift register.
   function automatic logic [OUT_WIDTH-1:0] head(input logic [DATA_WIDTH-1:0] w);
      if (MSB_FIRST != 0) return w[DATA_WIDTH-1 -: OUT_WIDTH];
      else                return w[OUT_WIDTH-1:0];
   endfunction

   assign hs        = valid_q && m_ready;
   assign last_hs   = hs && last_q;
   assign sreg_next = (MSB_FIRST != 0) ? (sreg_q << OUT_WIDTH) : (sreg_q >> OUT_WIDTH);

   // Reading on the final handshake lets the next word land during the single LOAD bubble.
   assign fifo_rd_en = rst_n && enable && !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == SEND) && last_hs));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (fifo_rd_en) state_d = LOAD;
         end
         LOAD: begin
            sreg_d  = fifo_data;
            cnt_d   = '0;
            valid_d = 1'b1;
            data_d  = head(fifo_data);
            last_d  = (NSLICE == 1);
            state_d = SEND;
         end
         SEND: begin
            if (hs) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  data_d  = '0;
                  last_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = fifo_rd_en ? LOAD : IDLE;
               end else begin
                  cnt_d  = cnt_q + CW'(1);
                  sreg_d = sreg_next;
                  data_d = head(sreg_next);
                  last_d = (cnt_d == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign m_valid = valid_q;
   assign m_data  = data_q;
   assign m_last  = last_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Drives an LSB-first and an MSB-first instance from one FIFO model; a monitor
// scores both against hand-written slice sequences and a small transfer model.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

   logic        clk = 1'b0;
   logic        rst_n, enable, m_ready, hold_empty, fifo_empty;
   logic [31:0] fifo_data = '0;
   logic        rd0, rd1, v0, v1, l0, l1;
   logic [7:0]  d0, d1;

   // Written only by the stimulus process.
   logic [31:0] mem   [16];
   logic [31:0] wexp0 [16];
   logic [31:0] wexp1 [16];
   int          wr_ptr = 0;
   logic        done   = 1'b0;

   // Written only by the FIFO model.
   int          rd_ptr = 0;

   // Written only by the monitor.
   typedef enum int {M_IDLE, M_LOAD, M_SEND} ms_t;
   ms_t  ms;
   int   k, cw, words_done, cyc, total, bad;
   logic exp_rd;

   always #5 clk = ~clk;

   assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

   fifo_rd_stream #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) u0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd0), .fifo_data(fifo_data), .m_valid(v0), .m_ready(m_ready),
      .m_data(d0), .m_last(l0));

   fifo_rd_stream #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd1), .fifo_data(fifo_data), .m_valid(v1), .m_ready(m_ready),
      .m_data(d1), .m_last(l1));

   // Registered-output FIFO: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (rd0) begin
         fifo_data <= mem[rd_ptr[3:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   function automatic logic [7:0] sl(input logic [31:0] seq, input int idx);
      return seq[31 - 8*idx -: 8];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // seq_lsb / seq_msb list the expected slices in send order, first slice in the top byte.
   task automatic push(input logic [31:0] w, input logic [31:0] seq_lsb, input logic [31:0] seq_msb);
      mem[wr_ptr[3:0]]   = w;
      wexp0[wr_ptr[3:0]] = seq_lsb;
      wexp1[wr_ptr[3:0]] = seq_msb;
      wr_ptr = wr_ptr + 1;
   endtask

   // Stimulus
   initial begin
      rst_n = 1'b0; enable = 1'b0; m_ready = 1'b1; hold_empty = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Held-empty FIFO must never be read; then a single word drains.
      hold_empty = 1'b1; enable = 1'b1;
      push(32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);
      tick(5);
      hold_empty = 1'b0;
      tick(10);

      // Back-to-back words.
      push(32'h11223344, 32'h44332211, 32'h11223344);
      push(32'h55667788, 32'h88776655, 32'h55667788);
      tick(14);

      // Backpressure on the second slice for 3 cycles.
      push(32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);
      tick(3);
      m_ready = 1'b0;
      tick(3);
      m_ready = 1'b1;
      tick(8);

      // Enable dropped after the first slice: word completes, next word waits.
      push(32'hCAFEF00D, 32'h0DF0FECA, 32'hCAFEF00D);
      push(32'h01020304, 32'h04030201, 32'h01020304);
      tick(3);
      enable = 1'b0;
      tick(10);
      enable = 1'b1;
      tick(10);

      // Asynchronous reset mid-cycle while the third slice is on the wire.
      push(32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);
      tick(4);
      #2;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      push(32'h5A6B7C8D, 32'h8D7C6B5A, 32'h5A6B7C8D);
      tick(10);
      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      ms = M_IDLE; k = 0; cw = 0; words_done = 0; cyc = 0; total = 0; bad = 0; exp_rd = 1'b0;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (!rst_n) begin
            chk("reset_u0", 32'({v0, l0, rd0, d0}), 32'd0);
            chk("reset_u1", 32'({v1, l1, rd1, d1}), 32'd0);
            ms = M_IDLE;
            k  = 0;
         end else if (!clk) begin
            exp_rd = enable && !fifo_empty &&
                     ((ms == M_IDLE) || ((ms == M_SEND) && m_ready && (k == 3)));
            chk("rd_en_u0", 32'(rd0), 32'(exp_rd));
            chk("rd_en_u1", 32'(rd1), 32'(exp_rd));
            chk("valid_u0", 32'(v0), 32'(ms == M_SEND));
            chk("valid_u1", 32'(v1), 32'(ms == M_SEND));
            if (ms == M_SEND) begin
               chk("data_u0", 32'(d0), 32'(sl(wexp0[cw[3:0]], k)));
               chk("data_u1", 32'(d1), 32'(sl(wexp1[cw[3:0]], k)));
               chk("last_u0", 32'(l0), 32'(k == 3));
               chk("last_u1", 32'(l1), 32'(k == 3));
            end else begin
               chk("idle_out_u0", 32'({l0, d0}), 32'd0);
               chk("idle_out_u1", 32'({l1, d1}), 32'd0);
            end
            case (ms)
               M_IDLE: if (exp_rd) begin ms = M_LOAD; cw = rd_ptr; end
               M_LOAD: begin ms = M_SEND; k = 0; end
               default: begin
                  if (m_ready) begin
                     if (k == 3) begin
                        words_done++;
                        if (exp_rd) begin ms = M_LOAD; cw = rd_ptr; end
                        else        ms = M_IDLE;
                     end else begin
                        k++;
                     end
                  end
               end
            endcase
         end
         if (!clk) begin
            cyc++;
            if (cyc > 2000) begin
               chk("watchdog", 32'(cyc), 32'd2000);
               $display("test done: total=%0d bad=%0d", total, bad);
               $finish;
            end
            if (done) begin
               chk("words_read", 32'(rd_ptr), 32'd8);
               chk("words_completed", 32'(words_done), 32'd7);
               chk("end_idle", 32'({v0, v1}), 32'd0);
               $display("test done: total=%0d bad=%0d", total, bad);
               $finish;
            end
         end
      end
   end

endmodule
